// File: rtl/cbus_arb_pkg.sv
// Shared types and constants for the CBUS round-robin arbiter.
// The optional grant timeout is enabled by defining CBUS_ARB_TMO_EN.
package cbus_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam logic [9:0]  CBUS_BYTECNT   = 10'h4;
   localparam logic [31:0] CBUS_TMO_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Requester-side and bridge-side CBUS bundles used by cbus_rr_arbiter.
// Handshake: a master raises req with cmd/address/wdata/byten and holds them
// until the slave pulses waccept (write) or rresp (read) for one cycle; read
// data is valid on rdatap the cycle after rresp. Dropping req abandons it.

interface cbus_rq_if #(
   parameter int NREQ  = 4,
   parameter int ADDRW = 8
);
   logic [NREQ-1:0]       rq_req;
   logic [NREQ-1:0]       rq_cmd;
   logic [NREQ*ADDRW-1:0] rq_address;
   logic [NREQ*32-1:0]    rq_wdata;
   logic [NREQ*4-1:0]     rq_byten;
   logic [NREQ-1:0]       rq_waccept;
   logic [NREQ-1:0]       rq_rresp;
   logic [31:0]           rq_rdatap;

   modport master (
      output rq_req, rq_cmd, rq_address, rq_wdata, rq_byten,
      input  rq_waccept, rq_rresp, rq_rdatap
   );
   modport slave (
      input  rq_req, rq_cmd, rq_address, rq_wdata, rq_byten,
      output rq_waccept, rq_rresp, rq_rdatap
   );
endinterface

interface cbus_m_if #(
   parameter int ADDRW = 8
);
   logic             cbus_m_req;
   logic             cbus_m_cmd;
   logic [ADDRW-1:0] cbus_m_address;
   logic [31:0]      cbus_m_wdata;
   logic [3:0]       cbus_m_byten;
   logic [9:0]       cbus_m_bytecnt;
   logic             cbus_m_first;
   logic             cbus_m_last;
   logic             cbus_m_waccept;
   logic             cbus_m_rresp;
   logic [31:0]      cbus_m_rdatap;

   modport master (
      output cbus_m_req, cbus_m_cmd, cbus_m_address, cbus_m_wdata, cbus_m_byten,
             cbus_m_bytecnt, cbus_m_first, cbus_m_last,
      input  cbus_m_waccept, cbus_m_rresp, cbus_m_rdatap
   );
   modport slave (
      input  cbus_m_req, cbus_m_cmd, cbus_m_address, cbus_m_wdata, cbus_m_byten,
             cbus_m_bytecnt, cbus_m_first, cbus_m_last,
      output cbus_m_waccept, cbus_m_rresp, cbus_m_rdatap
   );
endinterface

// File: rtl/cbus_rr_pick.sv
// Combinational round-robin picker: first requesting index after i_last,
// wrapping modulo NREQ.
module cbus_rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_last,
   output logic [$clog2(NREQ)-1:0] o_winner,
   output logic                    o_valid
);
   localparam int IW = $clog2(NREQ);

   logic [IW:0] w_sum;

   // Scan farthest-first so the nearest requester after i_last is written last.
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_sum    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         w_sum = {1'b0, i_last} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(NREQ)) begin
            w_sum = w_sum - (IW+1)'(NREQ);
         end
         if (i_req[w_sum[IW-1:0]]) begin
            o_winner = w_sum[IW-1:0];
            o_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one single-transfer CBUS master port among NREQ
// requesters. Optional grant timeout: define CBUS_ARB_TMO_EN.
module cbus_rr_arbiter
   import cbus_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int ADDRW   = 8,
   parameter int TMO_CYC = 255
) (
   input  logic        cbus_m_clk,
   input  logic        cbus_m_rst,
   cbus_rq_if.slave    rq,
   cbus_m_if.master    cbus_m,
   output logic        arb_tmo_err,
   output arb_state_e  o_dbg_state
);
   localparam int IW = $clog2(NREQ);

   arb_state_e       r_state, w_state_nxt;
   logic [IW-1:0]    r_gnt, w_gnt_nxt;
   logic [IW-1:0]    r_last, w_last_nxt;
   logic [IW-1:0]    w_pick;
   logic             w_pick_vld;
   logic             w_busy, w_done, w_tmo, w_force_rd;
   logic             w_sel_req, w_sel_cmd;
   logic [ADDRW-1:0] w_sel_addr;
   logic [31:0]      w_sel_wdata;
   logic [3:0]       w_sel_byten;
   logic [NREQ-1:0]  w_onehot;

   cbus_rr_pick #(.NREQ(NREQ)) u_pick (
      .i_req    (rq.rq_req),
      .i_last   (r_last),
      .o_winner (w_pick),
      .o_valid  (w_pick_vld)
   );

   always_comb begin
      w_sel_req   = 1'b0;
      w_sel_cmd   = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_byten = '0;
      w_onehot    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gnt == IW'(i)) begin
            w_sel_req   = rq.rq_req[i];
            w_sel_cmd   = rq.rq_cmd[i];
            w_sel_addr  = rq.rq_address[i*ADDRW +: ADDRW];
            w_sel_wdata = rq.rq_wdata[i*32 +: 32];
            w_sel_byten = rq.rq_byten[i*4 +: 4];
            w_onehot[i] = 1'b1;
         end
      end
   end

   assign w_busy = (r_state == BUSY);
   // A transfer ends on a response, on the requester abandoning it, or on timeout.
   assign w_done = w_busy & (cbus_m.cbus_m_waccept | cbus_m.cbus_m_rresp | ~w_sel_req | w_tmo);

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (w_pick_vld) begin
               w_gnt_nxt   = w_pick;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (w_done) begin
               w_last_nxt  = r_gnt;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge cbus_m_clk or posedge cbus_m_rst) begin
      if (cbus_m_rst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_last  <= IW'(NREQ-1);
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_last  <= w_last_nxt;
      end
   end

`ifdef CBUS_ARB_TMO_EN
   localparam int CW = $clog2(TMO_CYC+1);
   logic [CW-1:0] r_cnt;
   logic          r_tmo_d;

   assign w_tmo = w_busy & (r_cnt == CW'(TMO_CYC));

   always_ff @(posedge cbus_m_clk or posedge cbus_m_rst) begin
      if (cbus_m_rst) begin
         r_cnt   <= '0;
         r_tmo_d <= 1'b0;
      end else begin
         r_tmo_d <= w_tmo;
         r_cnt   <= (w_busy && !w_done) ? r_cnt + 1'b1 : '0;
      end
   end

   assign w_force_rd = r_tmo_d;
`else
   assign w_tmo      = 1'b0;
   assign w_force_rd = 1'b0;
`endif

   assign arb_tmo_err = w_tmo;
   assign o_dbg_state = r_state;

   assign cbus_m.cbus_m_req     = w_busy & w_sel_req;
   assign cbus_m.cbus_m_cmd     = w_busy & w_sel_cmd;
   assign cbus_m.cbus_m_address = w_busy ? w_sel_addr  : '0;
   assign cbus_m.cbus_m_wdata   = w_busy ? w_sel_wdata : '0;
   assign cbus_m.cbus_m_byten   = w_busy ? w_sel_byten : '0;
   assign cbus_m.cbus_m_bytecnt = CBUS_BYTECNT;
   assign cbus_m.cbus_m_first   = cbus_m.cbus_m_req;
   assign cbus_m.cbus_m_last    = cbus_m.cbus_m_req;

   // Responses reach only the granted requester and only while BUSY.
   assign rq.rq_waccept = (w_busy & (cbus_m.cbus_m_waccept | (w_tmo & ~w_sel_cmd))) ? w_onehot : '0;
   assign rq.rq_rresp   = (w_busy & (cbus_m.cbus_m_rresp   | (w_tmo &  w_sel_cmd))) ? w_onehot : '0;
   assign rq.rq_rdatap  = w_force_rd ? CBUS_TMO_RDATA : cbus_m.cbus_m_rdatap;

endmodule
